// File: rtl/lsu_master_pkg.sv
// Shared definitions for the load/store initiator: funct3 codes, FSM
// states, byte-lane size masks and small decode helpers.
package lsu_master_pkg;

   // RV32 funct3 encodings for loads and stores
   localparam logic [2:0] F3_B  = 3'b000;
   localparam logic [2:0] F3_H  = 3'b001;
   localparam logic [2:0] F3_W  = 3'b010;
   localparam logic [2:0] F3_BU = 3'b100;
   localparam logic [2:0] F3_HU = 3'b101;

   // Byte-lane masks for an access starting at lane 0
   localparam logic [3:0] MASK_B = 4'b0001;
   localparam logic [3:0] MASK_H = 4'b0011;
   localparam logic [3:0] MASK_W = 4'b1111;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_BEAT0 = 2'd1,
      ST_BEAT1 = 2'd2,
      ST_RESP  = 2'd3
   } lsu_state_t;

   // Lane mask for the access size encoded in funct3[1:0]
   function automatic logic [3:0] size_mask(input logic [2:0] f3);
      case (f3[1:0])
         2'b00:   return MASK_B;
         2'b01:   return MASK_H;
         default: return MASK_W;
      endcase
   endfunction

   // Unsigned variants exist only for loads; 011/110/111 are never legal
   function automatic logic is_illegal(input logic we, input logic [2:0] f3);
      logic ill;
      case (f3)
         F3_B, F3_H, F3_W: ill = 1'b0;
         F3_BU, F3_HU:     ill = we;
         default:          ill = 1'b1;
      endcase
      return ill;
   endfunction

endpackage

// File: rtl/lsu_master_align.sv
// Combinational lane steering: byte enables and positioned write data for
// both beats, the word-crossing flag, and extraction/extension of load data.
module lsu_master_align
   import lsu_master_pkg::*;
(
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   input  logic [31:0] wdata,
   input  logic [31:0] hi,
   input  logic [31:0] lo,
   output logic [3:0]  be0,
   output logic [3:0]  be1,
   output logic [31:0] wdata0,
   output logic [31:0] wdata1,
   output logic        crossing,
   output logic [31:0] rdata
);

   logic [7:0]  be_wide;
   logic [63:0] wd_wide;
   logic [31:0] rd_sh;

   // Shift the lane mask and data across a two-word window; the upper word is the second beat
   always_comb begin
      be_wide  = {4'b0000, size_mask(funct3)} << off;
      wd_wide  = {32'h0, wdata} << {off, 3'b000};
      rd_sh    = 32'({hi, lo} >> {off, 3'b000});
      be0      = be_wide[3:0];
      be1      = be_wide[7:4];
      wdata0   = wd_wide[31:0];
      wdata1   = wd_wide[63:32];
      crossing = ((funct3[1:0] == 2'b01) && (off == 2'd3)) ||
                 ((funct3[1:0] == 2'b10) && (off != 2'd0));
      case (funct3[1:0])
         2'b00:   rdata = funct3[2] ? {24'h0, rd_sh[7:0]}  : {{24{rd_sh[7]}}, rd_sh[7:0]};
         2'b01:   rdata = funct3[2] ? {16'h0, rd_sh[15:0]} : {{16{rd_sh[15]}}, rd_sh[15:0]};
         default: rdata = rd_sh;
      endcase
   end

endmodule

// File: rtl/lsu_master.sv
// Load/store initiator: accepts one RV32 load/store, issues one or two
// word-aligned memory beats with byte enables, and returns a one-cycle
// response carrying extended load data or an illegal-funct3 error.
module lsu_master
   import lsu_master_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [2:0]            req_funct3,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  resp_valid,
   output logic [DATA_WIDTH-1:0] resp_rdata,
   output logic                  resp_err,
   output logic                  mem_req,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   output logic [3:0]            mem_be,
   input  logic                  mem_ack,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   lsu_state_t            state;
   logic                  we_q;
   logic [2:0]            funct3_q;
   logic [1:0]            off_q;
   logic [DATA_WIDTH-1:0] wdata_q;
   logic [DATA_WIDTH-1:0] lo_q;
   logic [DATA_WIDTH-1:0] hi_q;

   logic [1:0]            sel_off;
   logic [2:0]            sel_funct3;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [DATA_WIDTH-1:0] lo_next;
   logic [DATA_WIDTH-1:0] hi_next;

   logic [3:0]            be0;
   logic [3:0]            be1;
   logic [DATA_WIDTH-1:0] wdata0;
   logic [DATA_WIDTH-1:0] wdata1;
   logic                  crossing;
   logic [DATA_WIDTH-1:0] ext_rdata;

   // In IDLE steer the incoming request so beat 0 can be registered on accept;
   // during a beat fold in the word arriving now so the response is ready on the last ack
   always_comb begin
      sel_off    = (state == ST_IDLE)  ? req_addr[1:0] : off_q;
      sel_funct3 = (state == ST_IDLE)  ? req_funct3    : funct3_q;
      sel_wdata  = (state == ST_IDLE)  ? req_wdata     : wdata_q;
      lo_next    = (state == ST_BEAT0) ? mem_rdata     : lo_q;
      hi_next    = (state == ST_BEAT1) ? mem_rdata     : hi_q;
   end

   lsu_master_align u_align (
      .off      (sel_off),
      .funct3   (sel_funct3),
      .wdata    (sel_wdata),
      .hi       (hi_next),
      .lo       (lo_next),
      .be0      (be0),
      .be1      (be1),
      .wdata0   (wdata0),
      .wdata1   (wdata1),
      .crossing (crossing),
      .rdata    (ext_rdata)
   );

   // Control FSM with registered handshake outputs; beat 1 starts with one idle request cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= ST_IDLE;
         we_q       <= 1'b0;
         funct3_q   <= 3'b000;
         off_q      <= 2'b00;
         wdata_q    <= '0;
         lo_q       <= '0;
         hi_q       <= '0;
         req_ready  <= 1'b1;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
         mem_req    <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         mem_be     <= 4'b0000;
      end else begin
         case (state)
            ST_IDLE: begin
               if (req_valid && req_ready) begin
                  we_q      <= req_we;
                  funct3_q  <= req_funct3;
                  off_q     <= req_addr[1:0];
                  wdata_q   <= req_wdata;
                  lo_q      <= '0;
                  hi_q      <= '0;
                  req_ready <= 1'b0;
                  if (is_illegal(req_we, req_funct3)) begin
                     state      <= ST_RESP;
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                  end else begin
                     state     <= ST_BEAT0;
                     mem_req   <= 1'b1;
                     mem_we    <= req_we;
                     mem_addr  <= {req_addr[ADDR_WIDTH-1:2], 2'b00};
                     mem_be    <= be0;
                     mem_wdata <= wdata0;
                  end
               end
            end
            ST_BEAT0: begin
               if (mem_ack) begin
                  lo_q <= mem_rdata;
                  if (crossing) begin
                     state     <= ST_BEAT1;
                     mem_req   <= 1'b0;
                     mem_addr  <= mem_addr + ADDR_WIDTH'(4);
                     mem_be    <= be1;
                     mem_wdata <= wdata1;
                  end else begin
                     state      <= ST_RESP;
                     mem_req    <= 1'b0;
                     mem_we     <= 1'b0;
                     mem_addr   <= '0;
                     mem_be     <= 4'b0000;
                     mem_wdata  <= '0;
                     resp_valid <= 1'b1;
                     resp_rdata <= we_q ? '0 : ext_rdata;
                  end
               end
            end
            ST_BEAT1: begin
               if (!mem_req) begin
                  mem_req <= 1'b1;
               end else if (mem_ack) begin
                  hi_q       <= mem_rdata;
                  state      <= ST_RESP;
                  mem_req    <= 1'b0;
                  mem_we     <= 1'b0;
                  mem_addr   <= '0;
                  mem_be     <= 4'b0000;
                  mem_wdata  <= '0;
                  resp_valid <= 1'b1;
                  resp_rdata <= we_q ? '0 : ext_rdata;
               end
            end
            ST_RESP: begin
               state      <= ST_IDLE;
               resp_valid <= 1'b0;
               resp_err   <= 1'b0;
               resp_rdata <= '0;
               req_ready  <= 1'b1;
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_lsu_master.sv
// Bench for lsu_master: a sparse byte-addressed memory answers beats with
// random delay; a byte-level reference model predicts responses, beat
// lanes and final memory contents for directed and random requests.
module tb_lsu_master;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic [2:0]  req_funct3;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_be;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   int cmp_count = 0;
   int mis_count = 0;

   logic        ack_en     = 1'b1;
   logic        stray_ack  = 1'b0;
   int          max_delay  = 0;
   int          delay      = 0;

   logic [7:0]  dut_mem [logic [31:0]];
   logic [7:0]  ref_mem [logic [31:0]];

   logic [31:0] q_addr [$];
   logic [3:0]  q_be   [$];
   logic [31:0] q_wd   [$];
   logic        q_we   [$];

   lsu_master dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_funct3 (req_funct3),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .resp_err   (resp_err),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_be     (mem_be),
      .mem_ack    (mem_ack),
      .mem_rdata  (mem_rdata)
   );

   always #5 clk = ~clk;

   // Background contents for never-written bytes
   function automatic logic [7:0] init_byte(input logic [31:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA5;
   endfunction

   function automatic logic [7:0] dut_byte(input logic [31:0] a);
      if (dut_mem.exists(a)) return dut_mem[a];
      return init_byte(a);
   endfunction

   function automatic logic [7:0] ref_byte(input logic [31:0] a);
      if (ref_mem.exists(a)) return ref_mem[a];
      return init_byte(a);
   endfunction

   task automatic set_word(input logic [31:0] a, input logic [31:0] w);
      for (int j = 0; j < 4; j++) begin
         ref_mem[a + 32'(j)] = w[8*j +: 8];
         dut_mem[a + 32'(j)] = w[8*j +: 8];
      end
   endtask

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      cmp_count++;
      if (obs !== exp) begin
         mis_count++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Memory responder: acks a pending beat after a random delay, applies byte-enabled writes
   initial begin
      mem_ack   = 1'b0;
      mem_rdata = 32'h0;
      forever begin
         @(posedge clk);
         #1;
         if (mem_ack) begin
            mem_ack   = 1'b0;
            mem_rdata = 32'h0;
            delay     = $urandom_range(0, max_delay);
         end else if (ack_en && mem_req && !reset) begin
            if (delay == 0) begin
               logic [31:0] w;
               for (int j = 0; j < 4; j++) w[8*j +: 8] = dut_byte(mem_addr + 32'(j));
               if (mem_we)
                  for (int j = 0; j < 4; j++)
                     if (mem_be[j]) dut_mem[mem_addr + 32'(j)] = mem_wdata[8*j +: 8];
               q_addr.push_back(mem_addr);
               q_be.push_back(mem_be);
               q_wd.push_back(mem_wdata);
               q_we.push_back(mem_we);
               mem_rdata = w;
               mem_ack   = 1'b1;
            end else begin
               delay--;
            end
         end else begin
            mem_ack = stray_ack;
         end
      end
   end

   // Issue one request, wait for its response, and check it against the byte-level reference
   task automatic applyStimulus(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wdata, output logic [31:0] got_rdata,
                                output int lat);
      int          wait_cnt;
      logic        got_err;
      logic        illegal;
      int          size;
      int          nexp;
      logic [31:0] word0;
      logic [31:0] b;
      logic [3:0]  exp_be [2];
      logic [31:0] exp_wd [2];
      logic [31:0] v;
      logic [31:0] exp_rd;
      logic [63:0] dwin;
      logic [63:0] rwin;
      logic [31:0] lmask;

      got_rdata = 32'h0;
      lat       = 0;
      wait_cnt  = 0;
      while (!req_ready && wait_cnt < 20) begin
         @(posedge clk); #1;
         wait_cnt++;
      end
      if (!req_ready) begin
         checkOutput("ready_timeout", 64'(req_ready), 64'd1);
         return;
      end
      q_addr.delete(); q_be.delete(); q_wd.delete(); q_we.delete();
      req_valid  = 1'b1;
      req_we     = we;
      req_funct3 = f3;
      req_addr   = addr;
      req_wdata  = wdata;
      @(posedge clk); #1;
      req_valid  = 1'b0;
      req_we     = 1'($urandom);
      req_funct3 = 3'($urandom);
      req_addr   = $urandom;
      req_wdata  = $urandom;
      while (!resp_valid && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
      if (!resp_valid) begin
         checkOutput("resp_timeout", 64'(resp_valid), 64'd1);
         return;
      end
      got_rdata = resp_rdata;
      got_err   = resp_err;
      @(posedge clk); #1;
      checkOutput("resp_pulse", 64'(resp_valid), 64'd0);
      checkOutput("ready_back", 64'(req_ready), 64'd1);

      if (we) illegal = (f3 > 3'd2);
      else    illegal = !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      checkOutput("resp_err", 64'(got_err), 64'(illegal));
      if (illegal) begin
         checkOutput("err_beats", 64'(q_addr.size()), 64'd0);
         checkOutput("err_rdata", 64'(got_rdata), 64'd0);
         return;
      end

      size      = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
      word0     = addr & 32'hFFFF_FFFC;
      exp_be[0] = 4'b0; exp_be[1] = 4'b0;
      exp_wd[0] = 32'h0; exp_wd[1] = 32'h0;
      for (int i = 0; i < size; i++) begin
         int k;
         b = addr + 32'(i);
         k = ((b & 32'hFFFF_FFFC) == word0) ? 0 : 1;
         exp_be[k][b[1:0]]        = 1'b1;
         exp_wd[k][8*b[1:0] +: 8] = wdata[8*i +: 8];
      end
      nexp = (exp_be[1] != 4'b0) ? 2 : 1;
      checkOutput("beats", 64'(q_addr.size()), 64'(nexp));
      for (int k = 0; k < nexp && k < q_addr.size(); k++) begin
         checkOutput("beat_we_addr_be", {27'h0, q_we[k], q_addr[k], q_be[k]},
                     {27'h0, we, word0 + 32'(4*k), exp_be[k]});
         if (we) begin
            for (int j = 0; j < 4; j++) lmask[8*j +: 8] = {8{exp_be[k][j]}};
            checkOutput("beat_wdata", 64'(q_wd[k] & lmask), 64'(exp_wd[k]));
         end
      end

      if (we) begin
         for (int i = 0; i < size; i++) ref_mem[addr + 32'(i)] = wdata[8*i +: 8];
         checkOutput("store_rdata", 64'(got_rdata), 64'd0);
         dwin = 64'h0; rwin = 64'h0;
         for (int j = 0; j < 8; j++) begin
            dwin |= 64'(dut_byte(word0 + 32'(j))) << (8*j);
            rwin |= 64'(ref_byte(word0 + 32'(j))) << (8*j);
         end
         checkOutput("store_mem", dwin, rwin);
      end else begin
         v = 32'h0;
         for (int i = 0; i < size; i++) v |= 32'(ref_byte(addr + 32'(i))) << (8*i);
         case (f3)
            3'd0:    exp_rd = {{24{v[7]}}, v[7:0]};
            3'd1:    exp_rd = {{16{v[15]}}, v[15:0]};
            3'd4:    exp_rd = {24'h0, v[7:0]};
            3'd5:    exp_rd = {16'h0, v[15:0]};
            default: exp_rd = v;
         endcase
         checkOutput("load_rdata", 64'(got_rdata), 64'(exp_rd));
      end
   endtask

   // Hard stop in case a wait escapes its bound
   initial begin
      #3000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   // Main sequence: reset state, directed cases, reset abort, then random traffic
   initial begin
      logic [31:0] rd;
      int          lat;
      logic        seen;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;

      reset      = 1'b1;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_funct3 = 3'b000;
      req_addr   = 32'h0;
      req_wdata  = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("rst_req_ready", 64'(req_ready), 64'd1);
      checkOutput("rst_mem", {27'h0, mem_req, mem_we, mem_be, mem_addr}, 64'd0);
      checkOutput("rst_resp", {30'h0, resp_valid, resp_err, resp_rdata}, 64'd0);
      checkOutput("rst_wdata", 64'(mem_wdata), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      max_delay = 0;
      set_word(32'h10, 32'hDEADBEEF);
      applyStimulus(1'b0, 3'b010, 32'h10, 32'h0, rd, lat);
      checkOutput("lw_aligned", 64'(rd), 64'hDEADBEEF);
      checkOutput("lw_latency", 64'(lat), 64'd1);

      set_word(32'h10, 32'h80112233);
      applyStimulus(1'b0, 3'b000, 32'h13, 32'h0, rd, lat);
      checkOutput("lb_sign", 64'(rd), 64'hFFFFFF80);
      applyStimulus(1'b0, 3'b100, 32'h13, 32'h0, rd, lat);
      checkOutput("lbu_zero", 64'(rd), 64'h00000080);

      applyStimulus(1'b1, 3'b001, 32'h13, 32'h0000ABCD, rd, lat);
      if (q_wd.size() == 2) begin
         checkOutput("sh_beat0_wdata", 64'(q_wd[0]), 64'hCD000000);
         checkOutput("sh_beat1_wdata", 64'(q_wd[1]), 64'h000000AB);
      end

      set_word(32'h0C, 32'h44332211);
      set_word(32'h10, 32'h88776655);
      applyStimulus(1'b0, 3'b010, 32'h0E, 32'h0, rd, lat);
      checkOutput("lw_cross", 64'(rd), 64'h66554433);

      applyStimulus(1'b0, 3'b011, 32'h20, 32'h0, rd, lat);
      checkOutput("err_latency", 64'(lat), 64'd0);
      applyStimulus(1'b1, 3'b100, 32'h20, 32'h1234, rd, lat);

      applyStimulus(1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, rd, lat);

      // Abort a stalled beat with reset; no response may follow, even on a stray ack
      ack_en = 1'b0;
      q_addr.delete(); q_be.delete(); q_wd.delete(); q_we.delete();
      req_valid  = 1'b1;
      req_we     = 1'b0;
      req_funct3 = 3'b010;
      req_addr   = 32'h20;
      @(posedge clk); #1;
      req_valid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      checkOutput("stall_mem_req", 64'(mem_req), 64'd1);
      reset = 1'b1;
      #1;
      checkOutput("abort_mem_req", 64'(mem_req), 64'd0);
      checkOutput("abort_ready", 64'(req_ready), 64'd1);
      @(posedge clk); #1;
      reset     = 1'b0;
      stray_ack = 1'b1;
      seen      = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         if (c == 1) stray_ack = 1'b0;
         if (resp_valid || mem_req || !req_ready) seen = 1'b1;
      end
      checkOutput("abort_no_resp", 64'(seen), 64'd0);
      ack_en = 1'b1;
      set_word(32'h20, 32'hCAFEF00D);
      applyStimulus(1'b0, 3'b010, 32'h20, 32'h0, rd, lat);
      checkOutput("lw_after_abort", 64'(rd), 64'hCAFEF00D);

      max_delay = 3;
      for (int n = 0; n < 300; n++) begin
         we = 1'($urandom);
         f3 = 3'($urandom);
         if ($urandom_range(0, 3) == 0) addr = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
         else                           addr = 32'($urandom_range(0, 63));
         applyStimulus(we, f3, addr, $urandom, rd, lat);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
      $finish;
   end

endmodule
